uart_tx_fifo_ctrl: RTL and testbench

- Transmit-side buffer and sequencer that sits directly upstream of the full-duplex UART top.
- Accepts bytes from a host through a write strobe and stores them in a circular FIFO.
- Drains the FIFO one byte per frame by driving the UART's send/data_in inputs, paced by the UART's tx_active_flag.
- Reports fill level, full/empty status, a sticky overflow error and a count of completed frames.

---
 rtl/uart_tx_fifo_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit FIFO and frame sequencer: buffers host bytes and drives send/data_in.
// Ports: host wr_en/wr_data/flush/clr_overflow in, UART send/data_in out, status out.
module uart_tx_fifo_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              clr_overflow,
  input  logic              tx_active_flag,
  output logic              send,
  output logic [7:0]        data_in,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    REQ,
    ACTIVE
  } state_t;

  localparam logic [ADDR_W:0] LVL_FULL =
    (ADDR_W+1)'(DEPTH);

  state_t state;
  state_t state_nx;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;

  logic pop;
  logic wr_ok;
  logic wr_drop;
  logic frame_done;

  assign pop   = (state == LOAD);
  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);
  assign busy  = (state != IDLE);

  // A pop frees a slot in the same edge, so a
  // write alongside LOAD is taken even when full.
  assign wr_ok   = wr_en & ~flush & (~full | pop);
  assign wr_drop = wr_en & ~flush & full & ~pop;

  assign frame_done =
    (state == ACTIVE) & ~tx_active_flag;

  // IDLE must not enter LOAD on a flush edge,
  // otherwise LOAD would pop an emptied FIFO.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!empty && !flush)
          state_nx = LOAD;
      end
      LOAD: begin
        state_nx = REQ;
      end
      REQ: begin
        if (tx_active_flag)
          state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (!tx_active_flag)
          state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Flush realigns rd_ptr to wr_ptr; any pop in
  // the same edge is subsumed by that realignment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (flush) begin
      level <= '0;
    end else if (wr_ok && !pop) begin
      level <= level + 1'b1;
    end else if (!wr_ok && pop) begin
      level <= level - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_in <= 8'h00;
    end else if (pop) begin
      data_in <= mem[rd_ptr];
    end
  end

  // send is high exactly while the FSM sits in REQ.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      send <= 1'b0;
    end else begin
      send <= (state_nx == REQ);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Testbench for uart_tx_fifo_ctrl: directed stimulus, byte scoreboard,
// and a simple UART model answering send with tx_active_flag.
module tb_uart_tx_fifo_ctrl;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              flush;
  logic              clr_overflow;
  logic              tx_active_flag;
  logic              send;
  logic [7:0]        data_in;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              busy;
  logic [CNT_W-1:0]  frame_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q [$];

  logic stall    = 1'b1;
  int   act_dly  = 5;
  int   act_hold = 20;

  uart_tx_fifo_ctrl #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .flush         (flush),
    .clr_overflow  (clr_overflow),
    .tx_active_flag(tx_active_flag),
    .send          (send),
    .data_in       (data_in),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name,
                           input int max);
    int n;
    n = 0;
    while (!((busy === 1'b0) && (empty === 1'b1) &&
             !tx_active_flag) && n < max) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n < max), 32'd1);
  endtask

  // UART model: acknowledge a pending send after
  // act_dly cycles and hold the line act_hold cycles.
  initial begin
    tx_active_flag = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && send && !stall) begin
        repeat (act_dly) @(negedge clock);
        tx_active_flag = 1'b1;
        repeat (act_hold) @(negedge clock);
        tx_active_flag = 1'b0;
      end
    end
  end

  // Monitor: each rising send presents one frame.
  logic send_prev = 1'b0;
  always @(negedge clock) begin
    if (reset_n && send && !send_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_send: got %0h expected none",
                 data_in);
      end else begin
        chk("frame_byte", 32'(data_in),
            32'(exp_q.pop_front()));
      end
    end
    send_prev = send;
  end

  initial begin
    int n;
    reset_n      = 1'b0;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    flush        = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) tick();

    chk("rst_send",     32'(send),        32'd0);
    chk("rst_data_in",  32'(data_in),     32'd0);
    chk("rst_empty",    32'(empty),       32'd1);
    chk("rst_full",     32'(full),        32'd0);
    chk("rst_level",    32'(level),       32'd0);
    chk("rst_overflow", 32'(overflow),    32'd0);
    chk("rst_busy",     32'(busy),        32'd0);
    chk("rst_frames",   32'(frame_count), 32'd0);

    reset_n = 1'b1;
    tick();

    // Single byte, UART acks 5 cycles after send
    stall    = 1'b0;
    act_dly  = 5;
    act_hold = 20;
    exp_q.push_back(8'hA5);
    wr(8'hA5);
    n = 1;
    while (!send && n < 50) begin
      tick();
      n++;
    end
    chk("send_latency", 32'(n), 32'd3);
    chk("single_data",  32'(data_in), 32'hA5);
    n = 0;
    while (!tx_active_flag && n < 50) begin
      tick();
      n++;
    end
    chk("send_held_req", 32'(send), 32'd1);
    tick();
    chk("send_fall",     32'(send), 32'd0);
    chk("busy_active",   32'(busy), 32'd1);
    wait_idle("single", 100);
    chk("single_frames", 32'(frame_count), 32'd1);
    chk("single_busy",   32'(busy),        32'd0);
    chk("single_empty",  32'(empty),       32'd1);
    chk("data_in_hold",  32'(data_in),     32'hA5);

    // Burst with UART stalled: 00 parks in REQ
    stall    = 1'b1;
    act_dly  = 2;
    act_hold = 3;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      wr(8'(i));
    end
    chk("burst_level15", 32'(level), 32'd15);
    chk("burst_notfull", 32'(full),  32'd0);
    exp_q.push_back(8'h10);
    wr(8'h10);
    chk("burst_level16", 32'(level), 32'd16);
    chk("burst_full",    32'(full),  32'd1);

    // Overflow: dropped byte, then clear
    wr(8'hFF);
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_level", 32'(level),    32'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    clr_overflow = 1'b1;
    wr(8'hFF);
    clr_overflow = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clr2", 32'(overflow), 32'd0);

    // Full plus pop: write during LOAD while full
    stall = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_gap_seen", 32'(n < 200), 32'd1);
    chk("full_at_idle",  32'(full),    32'd1);
    tick();
    exp_q.push_back(8'h11);
    wr(8'h11);
    chk("pop_wr_level", 32'(level),    32'd16);
    chk("pop_wr_ovf",   32'(overflow), 32'd0);
    wait_idle("burst", 3000);
    chk("burst_frames", 32'(frame_count), 32'd19);
    chk("burst_q_drained", 32'(exp_q.size()), 32'd0);

    // Flush together with a write: flush wins
    flush   = 1'b1;
    wr(8'h55);
    flush   = 1'b0;
    chk("flushwr_level", 32'(level),    32'd0);
    chk("flushwr_ovf",   32'(overflow), 32'd0);
    repeat (5) tick();
    chk("flushwr_busy",  32'(busy),     32'd0);

    // Flush during ACTIVE of the first of 4 bytes
    act_dly  = 2;
    act_hold = 10;
    exp_q.push_back(8'h20);
    wr(8'h20);
    wr(8'h21);
    wr(8'h22);
    wr(8'h23);
    n = 0;
    while (!tx_active_flag && n < 50) begin
      tick();
      n++;
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_busy",  32'(busy),  32'd1);
    wait_idle("flush", 200);
    repeat (10) tick();
    chk("flush_frames", 32'(frame_count), 32'd20);
    chk("flush_nosend", 32'(send),        32'd0);

    // Reset while in REQ
    stall = 1'b1;
    exp_q.push_back(8'h30);
    wr(8'h30);
    n = 0;
    while (!send && n < 50) begin
      tick();
      n++;
    end
    chk("req_reached", 32'(send), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_send",   32'(send),        32'd0);
    chk("arst_data",   32'(data_in),     32'd0);
    chk("arst_empty",  32'(empty),       32'd1);
    chk("arst_frames", 32'(frame_count), 32'd0);
    chk("arst_busy",   32'(busy),        32'd0);
    tick();
    reset_n = 1'b1;
    stall   = 1'b0;
    tick();
    exp_q.push_back(8'h31);
    wr(8'h31);
    wait_idle("post_rst", 200);
    chk("post_rst_frames", 32'(frame_count), 32'd1);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
